scb_mul_sched: RTL

SCB_MUL_SCHED -- requirements
Module: scb_mul_sched

---
 rtl/scb_mul_sched_pkg.sv | 28 ++
 rtl/scb_mul_sched_if.sv | 32 +++
 rtl/scb_timeout_ctr.sv | 27 ++
 rtl/scb_mul_sched.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/scb_mul_sched_pkg.sv
// Shared definitions for the matrix-vector product scheduler: state encoding,
// size limits, index widths and the public-matrix index helper.
package scb_mul_sched_pkg;

    localparam int SCB_RANK_MAX = 4;
    localparam int SCB_TIMEOUT  = 600;
    localparam int IDX_W        = $clog2(SCB_RANK_MAX);
    localparam int PUB_W        = $clog2(SCB_RANK_MAX * SCB_RANK_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_RUN,
        ST_GAP,
        ST_ROWOUT,
        ST_FIN
    } state_t;

    // Row-major index of matrix entry (i, j) for a matrix of rank rank_m1+1.
    function automatic logic [PUB_W-1:0] pub_index(input logic [IDX_W-1:0] i,
                                                   input logic [IDX_W-1:0] j,
                                                   input logic [IDX_W-1:0] rank_m1);
        logic [PUB_W-1:0] rank;
        rank = PUB_W'(rank_m1) + PUB_W'(1);
        return PUB_W'(i) * rank + PUB_W'(j);
    endfunction

endpackage

// File: rtl/scb_mul_sched_if.sv
// Job control, multiplier-core control and row-result handshake of the scheduler.
interface scb_mul_sched_if;
    import scb_mul_sched_pkg::*;

    logic             start;
    logic [IDX_W-1:0] l_sel;
    logic             busy;
    logic             done;
    logic             err;
    logic             mul_clr;
    logic             mul_sec_reload;
    logic             mul_start;
    logic             mul_done;
    logic [IDX_W-1:0] sec_sel;
    logic [PUB_W-1:0] pub_sel;
    logic             row_valid;
    logic [IDX_W-1:0] row_idx;
    logic             row_ack;

    modport master (
        input  start, l_sel, mul_done, row_ack,
        output busy, done, err, mul_clr, mul_sec_reload, mul_start,
               sec_sel, pub_sel, row_valid, row_idx
    );

    modport slave (
        output start, l_sel, mul_done, row_ack,
        input  busy, done, err, mul_clr, mul_sec_reload, mul_start,
               sec_sel, pub_sel, row_valid, row_idx
    );

endinterface

// File: rtl/scb_timeout_ctr.sv
// Loadable down-counter; expired is raised while enabled and the count has run out.
module scb_timeout_ctr #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && count_reg != '0) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign expired = en && (count_reg == '0);

endmodule

// File: rtl/scb_mul_sched.sv
// Schedules rank*rank multiplier-core products of a matrix-vector job, one row
// result at a time, with a per-product timeout.
module scb_mul_sched
    import scb_mul_sched_pkg::*;
#(
    parameter int RANK_MAX = SCB_RANK_MAX,
    parameter int TIMEOUT  = SCB_TIMEOUT
) (
    input logic             clk,
    input logic             rst,
    scb_mul_sched_if.master bus
);

    localparam int               CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] RANK_M1_MAX = IDX_W'(RANK_MAX - 1);

    state_t           state_reg;
    logic [IDX_W-1:0] rank_m1_reg;
    logic [IDX_W-1:0] i_reg;
    logic [IDX_W-1:0] j_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;
    logic             clr_reg;
    logic             reload_reg;
    logic             mstart_reg;
    logic             rvalid_reg;
    logic [IDX_W-1:0] ridx_reg;
    logic [IDX_W-1:0] sec_reg;
    logic [PUB_W-1:0] pub_reg;

    logic ctr_load;
    logic ctr_en;
    logic ctr_expired;

    // The timeout window is re-armed on every cycle outside RUN.
    assign ctr_en   = (state_reg == ST_RUN);
    assign ctr_load = !ctr_en;

    scb_timeout_ctr #(.W(CNT_W)) u_timeout_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .en       (ctr_en),
        .load_val (CNT_W'(TIMEOUT - 1)),
        .expired  (ctr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            rank_m1_reg <= '0;
            i_reg       <= '0;
            j_reg       <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            clr_reg     <= 1'b1;
            reload_reg  <= 1'b0;
            mstart_reg  <= 1'b0;
            rvalid_reg  <= 1'b0;
            ridx_reg    <= '0;
            sec_reg     <= '0;
            pub_reg     <= '0;
        end else begin
            done_reg   <= 1'b0;
            clr_reg    <= 1'b0;
            reload_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        rank_m1_reg <= (bus.l_sel > RANK_M1_MAX) ? RANK_M1_MAX : bus.l_sel;
                        i_reg       <= '0;
                        j_reg       <= '0;
                        err_reg     <= 1'b0;
                        busy_reg    <= 1'b1;
                        clr_reg     <= 1'b1;
                        sec_reg     <= '0;
                        pub_reg     <= '0;
                        state_reg   <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    mstart_reg <= 1'b1;
                    state_reg  <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.mul_done) begin
                        mstart_reg <= 1'b0;
                        state_reg  <= ST_GAP;
                        // Advance the selects now so they are settled for the reload.
                        if (j_reg != rank_m1_reg) begin
                            j_reg      <= j_reg + IDX_W'(1);
                            sec_reg    <= j_reg + IDX_W'(1);
                            pub_reg    <= pub_index(i_reg, j_reg + IDX_W'(1), rank_m1_reg);
                            reload_reg <= 1'b1;
                        end
                    end else if (ctr_expired) begin
                        err_reg    <= 1'b1;
                        busy_reg   <= 1'b0;
                        mstart_reg <= 1'b0;
                        sec_reg    <= '0;
                        pub_reg    <= '0;
                        state_reg  <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    // A pending reload means another product in this row remains.
                    if (reload_reg) begin
                        mstart_reg <= 1'b1;
                        state_reg  <= ST_RUN;
                    end else begin
                        rvalid_reg <= 1'b1;
                        ridx_reg   <= i_reg;
                        state_reg  <= ST_ROWOUT;
                    end
                end
                ST_ROWOUT: begin
                    if (bus.row_ack) begin
                        rvalid_reg <= 1'b0;
                        if (i_reg != rank_m1_reg) begin
                            i_reg     <= i_reg + IDX_W'(1);
                            j_reg     <= '0;
                            sec_reg   <= '0;
                            pub_reg   <= pub_index(i_reg + IDX_W'(1), '0, rank_m1_reg);
                            clr_reg   <= 1'b1;
                            state_reg <= ST_CLR;
                        end else begin
                            state_reg <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy           = busy_reg;
    assign bus.done           = done_reg;
    assign bus.err            = err_reg;
    assign bus.mul_clr        = clr_reg;
    assign bus.mul_sec_reload = reload_reg;
    assign bus.mul_start      = mstart_reg;
    assign bus.sec_sel        = sec_reg;
    assign bus.pub_sel        = pub_reg;
    assign bus.row_valid      = rvalid_reg;
    assign bus.row_idx        = ridx_reg;

endmodule
